// File: rtl/motor_mode_sequencer.sv
// Motor mode sequencer.
// Sequences the operating mode (IDLE/AUTO/MANUAL), the manual heat/cool
// direction with a forced dead time on reversal, the AUTO fan level derived
// from temperature, and an obstacle stop with a clear-reading hold-off.
// Every output comes straight from a register, so an input sampled on one
// rising edge shows up on the outputs right after that same edge.
module motor_mode_sequencer #(
    parameter int unsigned DEAD_TIME = 100,  // forced-stop cycles on heat<->cool reversal (expected >= 1)
    parameter int unsigned OBST_CM   = 5,    // obstacle when distance <= OBST_CM
    parameter int unsigned OBST_HOLD = 50,   // consecutive clear cycles before resuming
    parameter int unsigned T1        = 24,
    parameter int unsigned T2        = 27,
    parameter int unsigned T3        = 30
) (
    input  logic       clk,
    input  logic       reset,           // synchronous, active-low
    input  logic       btn_mode,
    input  logic       btn_hc,
    input  logic [7:0] temp,
    input  logic [9:0] distance,
    output logic [1:0] mode,
    output logic [1:0] heat_cool_stop,
    output logic [1:0] level,
    output logic       obstacle,
    output logic       busy
);

    // Operating modes (also the encoding driven on the mode output)
    localparam logic [1:0] MODE_IDLE   = 2'b00;
    localparam logic [1:0] MODE_AUTO   = 2'b01;
    localparam logic [1:0] MODE_MANUAL = 2'b10;

    // Direction states; HEAT/COOL/STOP double as the heat_cool_stop codes
    // and as the encoding of the stored request and the last driven direction
    // (STOP there meaning "no direction driven yet").
    localparam logic [1:0] DIR_HEAT = 2'd0;
    localparam logic [1:0] DIR_COOL = 2'd1;
    localparam logic [1:0] DIR_STOP = 2'd2;
    localparam logic [1:0] DIR_DEAD = 2'd3;

    // Counter widths cover the parameter values so saturation never wraps
    localparam int DEAD_W = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
    localparam int HOLD_W = (OBST_HOLD < 1) ? 1 : $clog2(OBST_HOLD + 1);
    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_TIME);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(OBST_HOLD);

    // Thresholds narrowed to the input widths for clean comparisons
    localparam logic [9:0] OBST_CM_C = 10'(OBST_CM);
    localparam logic [7:0] T1_C      = 8'(T1);
    localparam logic [7:0] T2_C      = 8'(T2);
    localparam logic [7:0] T3_C      = 8'(T3);

    // State registers
    logic [1:0]        mode_q,     mode_d;
    logic [1:0]        dir_q,      dir_d;
    logic [1:0]        req_q,      req_d;
    logic [1:0]        last_q,     last_d;
    logic [DEAD_W-1:0] dead_cnt_q, dead_cnt_d;
    logic              obst_q,     obst_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    // Output registers
    logic [1:0]        hcs_q,      hcs_d;
    logic [1:0]        level_q,    level_d;
    logic              busy_q,     busy_d;

    // Helpers
    logic              hc_evt;
    logic              near;
    logic              hold_done;
    logic              mode_switch;
    logic [DEAD_W-1:0] dead_inc;
    logic [HOLD_W-1:0] hold_inc;

    // Manual request sequence HEAT -> COOL -> STOP -> HEAT
    function automatic logic [1:0] step_req(input logic [1:0] r);
        case (r)
            DIR_HEAT: return DIR_COOL;
            DIR_COOL: return DIR_STOP;
            default:  return DIR_HEAT;
        endcase
    endfunction

    // AUTO fan level from temperature bands
    function automatic logic [1:0] temp_level(input logic [7:0] t);
        if (t >= T3_C) begin
            return 2'd3;
        end else if (t >= T2_C) begin
            return 2'd2;
        end else if (t >= T1_C) begin
            return 2'd1;
        end else begin
            return 2'd0;
        end
    endfunction

    // Next-state logic: mode, obstacle hold-off, direction FSM and outputs
    always_comb begin
        // Mode stepping; btn_mode wins over a simultaneous btn_hc
        mode_d = mode_q;
        if (btn_mode) begin
            case (mode_q)
                MODE_IDLE: mode_d = MODE_AUTO;
                MODE_AUTO: mode_d = MODE_MANUAL;
                default:   mode_d = MODE_IDLE;
            endcase
        end
        hc_evt      = btn_hc && !btn_mode && (mode_q == MODE_MANUAL);
        mode_switch = (mode_d != mode_q) &&
                      ((mode_q == MODE_MANUAL) || (mode_d == MODE_MANUAL));

        // Obstacle: any near reading (re)arms it, a run of clear readings releases it
        near      = (distance <= OBST_CM_C);
        hold_inc  = (hold_cnt_q == HOLD_MAX) ? hold_cnt_q : hold_cnt_q + 1'b1;
        obst_d    = obst_q;
        hold_cnt_d = hold_cnt_q;
        hold_done = 1'b0;
        if (mode_d == MODE_IDLE) begin
            obst_d     = 1'b0;
            hold_cnt_d = '0;
        end else if (near) begin
            obst_d     = 1'b1;
            hold_cnt_d = '0;
        end else if (obst_q) begin
            if (hold_inc >= HOLD_MAX) begin
                obst_d     = 1'b0;
                hold_cnt_d = '0;
                hold_done  = 1'b1;
            end else begin
                hold_cnt_d = hold_inc;
            end
        end

        // Direction FSM, live only while staying in MANUAL
        dead_inc   = (dead_cnt_q == DEAD_MAX) ? dead_cnt_q : dead_cnt_q + 1'b1;
        req_d      = req_q;
        dir_d      = dir_q;
        dead_cnt_d = dead_cnt_q;
        last_d     = last_q;
        if (mode_switch || (mode_q != MODE_MANUAL)) begin
            // Entering or leaving MANUAL (or not in it): everything back to STOP
            req_d      = DIR_STOP;
            dir_d      = DIR_STOP;
            dead_cnt_d = '0;
            if (mode_switch) begin
                last_d = DIR_STOP;
            end
        end else begin
            if (hc_evt) begin
                req_d = step_req(req_q);
            end
            if (obst_d) begin
                // Held stopped; requests keep being recorded for the resume
                dir_d      = DIR_STOP;
                dead_cnt_d = '0;
            end else if (hold_done) begin
                // Resume from the stored request; reversing the last driven
                // direction still has to wait out the dead time
                dead_cnt_d = '0;
                if (req_d == DIR_STOP) begin
                    dir_d = DIR_STOP;
                end else if ((last_q != DIR_STOP) && (last_q != req_d)) begin
                    dir_d = DIR_DEAD;
                end else begin
                    dir_d = req_d;
                end
            end else if (dir_q == DIR_DEAD) begin
                // btn_hc only moves the target; a STOP target ends the wait
                if (req_d == DIR_STOP) begin
                    dir_d      = DIR_STOP;
                    dead_cnt_d = '0;
                end else if (dead_inc >= DEAD_MAX) begin
                    dir_d      = req_d;
                    dead_cnt_d = '0;
                end else begin
                    dead_cnt_d = dead_inc;
                end
            end else if (hc_evt) begin
                if ((dir_q == DIR_HEAT) && (req_d == DIR_COOL)) begin
                    dir_d      = DIR_DEAD;
                    dead_cnt_d = '0;
                end else begin
                    dir_d = req_d;
                end
            end
        end
        if ((dir_d == DIR_HEAT) || (dir_d == DIR_COOL)) begin
            last_d = dir_d;
        end

        // Output values registered alongside the state
        hcs_d   = ((dir_d == DIR_HEAT) || (dir_d == DIR_COOL)) ? dir_d : DIR_STOP;
        busy_d  = (dir_d == DIR_DEAD);
        level_d = ((mode_d == MODE_AUTO) && !obst_d) ? temp_level(temp) : 2'd0;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            mode_q     <= MODE_IDLE;
            dir_q      <= DIR_STOP;
            req_q      <= DIR_STOP;
            last_q     <= DIR_STOP;
            dead_cnt_q <= '0;
            obst_q     <= 1'b0;
            hold_cnt_q <= '0;
            hcs_q      <= DIR_STOP;
            level_q    <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            dir_q      <= dir_d;
            req_q      <= req_d;
            last_q     <= last_d;
            dead_cnt_q <= dead_cnt_d;
            obst_q     <= obst_d;
            hold_cnt_q <= hold_cnt_d;
            hcs_q      <= hcs_d;
            level_q    <= level_d;
            busy_q     <= busy_d;
        end
    end

    assign mode           = mode_q;
    assign heat_cool_stop = hcs_q;
    assign level          = level_q;
    assign obstacle       = obst_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_motor_mode_sequencer.sv
// Self-checking bench for motor_mode_sequencer: directed scenarios with
// literal expectations, then randomized traffic against a behavioural model.
module tb_motor_mode_sequencer;

    localparam int DT = 100;
    localparam int OC = 5;
    localparam int OH = 50;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_hc = 1'b0;
    logic [7:0] temp = 8'd20;
    logic [9:0] distance = 10'd500;
    logic [1:0] mode;
    logic [1:0] heat_cool_stop;
    logic [1:0] level;
    logic       obstacle;
    logic       busy;

    motor_mode_sequencer #(
        .DEAD_TIME(DT), .OBST_CM(OC), .OBST_HOLD(OH),
        .T1(24), .T2(27), .T3(30)
    ) dut (
        .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_hc(btn_hc),
        .temp(temp), .distance(distance), .mode(mode),
        .heat_cool_stop(heat_cool_stop), .level(level),
        .obstacle(obstacle), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    // Behavioural model: mode 0/1/2, direction driven 0 heat/1 cool/2 stop,
    // remaining dead-time cycles, stored request, last heat/cool (-1 none)
    int m_mode, m_req, m_dir, m_dead_left, m_last, m_clear_run, m_level;
    bit m_obst;

    function automatic int lvl_of(int t);
        if (t >= 30) return 3;
        if (t >= 27) return 2;
        if (t >= 24) return 1;
        return 0;
    endfunction

    task automatic model_step(bit rst, bit bm, bit bh, int t, int d);
        int  nm;
        bit  hc;
        bit  done;
        if (!rst) begin
            m_mode = 0; m_req = 2; m_dir = 2; m_dead_left = 0; m_last = -1;
            m_clear_run = 0; m_level = 0; m_obst = 0;
            return;
        end
        nm   = bm ? (m_mode + 1) % 3 : m_mode;
        hc   = bh && !bm && (m_mode == 2);
        done = 0;
        if (nm == 0) begin
            m_obst = 0; m_clear_run = 0;
        end else if (d <= OC) begin
            m_obst = 1; m_clear_run = 0;
        end else if (m_obst) begin
            m_clear_run++;
            if (m_clear_run >= OH) begin
                m_obst = 0; m_clear_run = 0; done = 1;
            end
        end
        if (nm != m_mode && (nm == 2 || m_mode == 2)) begin
            m_req = 2; m_dir = 2; m_dead_left = 0; m_last = -1;
        end else if (nm == 2) begin
            if (hc) m_req = (m_req + 1) % 3;
            if (m_obst) begin
                m_dir = 2; m_dead_left = 0;
            end else if (done) begin
                if (m_req == 2) m_dir = 2;
                else if (m_last >= 0 && m_last != m_req) begin
                    m_dir = 2; m_dead_left = DT;
                end else m_dir = m_req;
            end else if (m_dead_left > 0) begin
                if (m_req == 2) m_dead_left = 0;
                else begin
                    m_dead_left--;
                    if (m_dead_left == 0) m_dir = m_req;
                end
            end else if (hc) begin
                if (m_dir == 0 && m_req == 1) begin
                    m_dir = 2; m_dead_left = DT;
                end else m_dir = m_req;
            end
            if (m_dir != 2) m_last = m_dir;
        end
        m_mode  = nm;
        m_level = (nm == 1 && !m_obst) ? lvl_of(t) : 0;
    endtask

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Literal expectation applied to both the DUT and the model
    task automatic lit(string name, int dut_val, int model_val, int exp);
        chk(name, dut_val, exp);
        chk({"model_", name}, model_val, exp);
    endtask

    // One clock cycle of stimulus; buttons are single-cycle pulses
    task automatic cyc(bit rst, bit bm, bit bh, int t, int d);
        reset    = rst;
        btn_mode = bm;
        btn_hc   = bh;
        temp     = 8'(t);
        distance = 10'(d);
        @(posedge clk);
        model_step(rst, bm, bh, t, d);
        #1;
        btn_mode = 1'b0;
        btn_hc   = 1'b0;
    endtask

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("mode", int'(mode), m_mode);
            chk("hcs", int'(heat_cool_stop), m_dir);
            chk("level", int'(level), m_level);
            chk("obstacle", int'(obstacle), int'(m_obst));
            chk("busy", int'(busy), (m_dead_left > 0) ? 1 : 0);
        end
    end

    initial begin
        int d;
        int t;
        int near_left;
        bit r;
        bit bm;
        bit bh;

        // Reset with buttons held: buttons must be ignored
        cyc(0, 1, 1, 20, 500);
        cyc(0, 1, 1, 20, 500);
        chk_on = 1'b1;
        lit("rst_mode", mode, m_mode, 0);
        lit("rst_hcs", heat_cool_stop, m_dir, 2);
        lit("rst_level", level, m_level, 0);
        lit("rst_obst", obstacle, m_obst, 0);
        lit("rst_busy", busy, (m_dead_left > 0), 0);

        // Mode stepping
        cyc(1, 1, 0, 20, 500); lit("mode_step1", mode, m_mode, 1);
        cyc(1, 0, 0, 20, 500); lit("mode_hold", mode, m_mode, 1);
        cyc(1, 1, 0, 20, 500); lit("mode_step2", mode, m_mode, 2);
        cyc(1, 1, 0, 20, 500); lit("mode_step3", mode, m_mode, 0);

        // MANUAL heat, then reversal through the dead time
        cyc(1, 1, 0, 20, 500);
        cyc(1, 1, 0, 20, 500); lit("man_mode", mode, m_mode, 2);
        cyc(1, 0, 1, 20, 500); lit("man_heat", heat_cool_stop, m_dir, 0);
        cyc(1, 0, 1, 20, 500);
        lit("dead_hcs", heat_cool_stop, m_dir, 2);
        lit("dead_busy", busy, (m_dead_left > 0), 1);
        for (int i = 1; i < DT; i++) begin
            cyc(1, 0, 0, 20, 500);
            lit("dead_busy_run", busy, (m_dead_left > 0), 1);
        end
        cyc(1, 0, 0, 20, 500);
        lit("dead_end_hcs", heat_cool_stop, m_dir, 1);
        lit("dead_end_busy", busy, (m_dead_left > 0), 0);

        // COOL -> STOP -> HEAT immediate, then abort a dead time with btn_mode+btn_hc
        cyc(1, 0, 1, 20, 500); lit("cool_stop", heat_cool_stop, m_dir, 2);
        cyc(1, 0, 1, 20, 500); lit("stop_heat", heat_cool_stop, m_dir, 0);
        cyc(1, 0, 1, 20, 500); lit("dead2_busy", busy, (m_dead_left > 0), 1);
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 20, 500);
        cyc(1, 1, 1, 20, 500);
        lit("abort_mode", mode, m_mode, 0);
        lit("abort_busy", busy, (m_dead_left > 0), 0);
        lit("abort_hcs", heat_cool_stop, m_dir, 2);

        // AUTO temperature sweep
        cyc(1, 1, 0, 23, 500); lit("auto_mode", mode, m_mode, 1);
        cyc(1, 0, 0, 23, 500); lit("lvl_23", level, m_level, 0);
        cyc(1, 0, 0, 24, 500); lit("lvl_24", level, m_level, 1);
        cyc(1, 0, 0, 27, 500); lit("lvl_27", level, m_level, 2);
        cyc(1, 0, 0, 29, 500); lit("lvl_29", level, m_level, 2);
        cyc(1, 0, 0, 30, 500); lit("lvl_30", level, m_level, 3);
        lit("auto_hcs", heat_cool_stop, m_dir, 2);

        // Obstacle with hold restart
        cyc(1, 0, 0, 30, 5);
        lit("obst_set", obstacle, m_obst, 1);
        lit("obst_lvl", level, m_level, 0);
        for (int i = 0; i < OH - 1; i++) cyc(1, 0, 0, 30, 6);
        lit("obst_49", obstacle, m_obst, 1);
        cyc(1, 0, 0, 30, 4); lit("obst_rearm", obstacle, m_obst, 1);
        for (int i = 0; i < OH - 1; i++) cyc(1, 0, 0, 30, 6);
        lit("obst_hold49", obstacle, m_obst, 1);
        lit("obst_hold49_lvl", level, m_level, 0);
        cyc(1, 0, 0, 30, 6);
        lit("obst_clear", obstacle, m_obst, 0);
        lit("obst_clear_lvl", level, m_level, 3);
        lit("obst_mode", mode, m_mode, 1);

        // Reset in the middle of a dead time
        cyc(1, 1, 0, 30, 500); lit("man2_mode", mode, m_mode, 2);
        cyc(1, 0, 1, 30, 500);
        cyc(1, 0, 1, 30, 500);
        for (int i = 1; i < 40; i++) cyc(1, 0, 0, 30, 500);
        lit("dead40_busy", busy, (m_dead_left > 0), 1);
        cyc(0, 1, 1, 30, 500);
        lit("mrst_mode", mode, m_mode, 0);
        lit("mrst_hcs", heat_cool_stop, m_dir, 2);
        lit("mrst_busy", busy, (m_dead_left > 0), 0);
        lit("mrst_obst", obstacle, m_obst, 0);
        lit("mrst_level", level, m_level, 0);
        cyc(1, 1, 0, 30, 500); lit("mrst_after", mode, m_mode, 1);

        // Randomized traffic against the model
        near_left = 0;
        for (int i = 0; i < 4000; i++) begin
            r  = ($urandom_range(0, 1499) != 0);
            bm = ($urandom_range(0, 59) == 0);
            if (i < 2000) bh = ($urandom_range(0, 11) == 0);
            else          bh = ($urandom_range(0, 149) == 0);
            if (near_left == 0 && $urandom_range(0, 199) == 0)
                near_left = $urandom_range(1, 8);
            if (near_left > 0) begin
                d = $urandom_range(0, OC);
                near_left--;
            end else if ($urandom_range(0, 9) == 0) begin
                d = OC + 1;
            end else begin
                d = $urandom_range(OC + 1, 1023);
            end
            t = $urandom_range(18, 36);
            cyc(r, bm, bh, t, d);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/motor_mode_sequencer.md
MOTOR_MODE_SEQUENCER -- requirements
Module: motor_mode_sequencer

Interface
REQ-001 Parameters SHALL be: DEAD_TIME, default 100, cycles of forced stop on heat<->cool reversal; OBST_CM, default 5, obstacle distance threshold in cm; OBST_HOLD, default 50, clear cycles needed before resuming; T1/T2/T3, defaults 24/27/30, temperature thresholds in degrees C.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-004 btn_mode  input  1  one-cycle pulse; advances operating mode.
REQ-005 btn_hc  input  1  one-cycle pulse; advances manual direction request.
REQ-006 temp  input  8  unsigned temperature, degrees C.
REQ-007 distance  input  10  unsigned obstacle distance, cm.
REQ-008 mode  output  2  00 IDLE, 01 AUTO, 10 MANUAL; 11 never driven.
REQ-009 heat_cool_stop  output  2  0 heat, 1 cool, 2 stop; 3 never driven.
REQ-010 level  output  2  AUTO fan level 0..3.
REQ-011 obstacle  output  1  high while obstacle stop or hold-off is active.
REQ-012 busy  output  1  high while the dead-time counter runs.

Function
REQ-013 All outputs SHALL be registered; a qualifying input change SHALL appear on the outputs exactly 1 cycle later.
REQ-014 Mode FSM states SHALL be IDLE, AUTO and MANUAL; btn_mode SHALL step IDLE->AUTO->MANUAL->IDLE, one step per pulse.
REQ-015 Direction FSM states SHALL be HEAT, COOL, STOP and DEAD; it SHALL be active only in MANUAL and SHALL be forced to STOP on entering or leaving MANUAL.
REQ-016 btn_hc in MANUAL SHALL step the request HEAT->COOL->STOP->HEAT; btn_hc outside MANUAL SHALL be ignored.
REQ-017 STOP->HEAT and STOP->COOL SHALL be immediate.
REQ-018 HEAT->COOL SHALL pass through DEAD: heat_cool_stop=2, busy=1 for exactly DEAD_TIME cycles, then COOL; busy SHALL drop in the same cycle COOL appears.
REQ-019 A btn_hc in DEAD SHALL advance the pending target (COOL->STOP) without restarting the counter; a STOP target SHALL end DEAD immediately.
REQ-020 btn_mode in DEAD SHALL abort the dead time: busy=0, heat_cool_stop=2, mode advances.
REQ-021 Simultaneous btn_mode and btn_hc SHALL act on btn_mode only.
REQ-022 In AUTO, level SHALL be 0 if temp<T1, 1 if T1<=temp<T2, 2 if T2<=temp<T3, and 3 if temp>=T3.
REQ-023 In AUTO, heat_cool_stop SHALL be 2.
REQ-024 Outside AUTO, level SHALL be 0.
REQ-025 Obstacle handling SHALL apply in AUTO or MANUAL only: distance<=OBST_CM SHALL set obstacle=1, force level=0 and heat_cool_stop=2, and keep mode unchanged.
REQ-026 Obstacle release SHALL require distance>OBST_CM for OBST_HOLD consecutive cycles; any reading <=OBST_CM SHALL restart the hold count.
REQ-027 On obstacle release, obstacle SHALL drop and normal outputs SHALL resume; the direction resumes from the stored request, and a HEAT/COOL request restarts from STOP through DEAD if the last driven direction was opposite.
REQ-028 Buttons SHALL still be processed during obstacle; only the outputs are overridden.
REQ-029 Entering IDLE SHALL clear obstacle and the hold counter.
REQ-030 The hold and dead counters SHALL saturate and never wrap; their widths SHALL cover the parameter values.

Reset
REQ-031 reset=0 at a clock edge SHALL give mode=00, heat_cool_stop=2, level=0, obstacle=0, busy=0, all counters 0 and the direction request STOP, regardless of state, including mid-DEAD or mid-hold.
REQ-032 Buttons asserted in the reset cycle SHALL be ignored.

Verification
REQ-033 Reset, then three btn_mode pulses -> mode 01, 10, 00, each 1 cycle after its pulse.
REQ-034 MANUAL, btn_hc x1 -> heat_cool_stop=0; btn_hc again -> heat_cool_stop=2, busy=1 for 100 cycles, then heat_cool_stop=1, busy=0.
REQ-035 AUTO, temp sweep 23, 24, 27, 29, 30 -> level 0, 1, 2, 2, 3.
REQ-036 AUTO, temp=30, distance 5 -> obstacle=1, level=0; distance 6 for 49 cycles then 4 -> still blocked; then 50 clear cycles -> level=3, obstacle=0.
REQ-037 MANUAL mid-DEAD, btn_mode and btn_hc in the same cycle -> mode=00, busy=0, heat_cool_stop=2.
REQ-038 reset=0 asserted at cycle 40 of DEAD -> all outputs at reset values on the next edge; btn_mode after release -> mode=01.
